llc_tx_queue: RTL and testbench
===============================

Name: llc_tx_queue

Overview:
- Transmit-request queue between the LLC and the FrameTransmitter.
- Buffers up to DEPTH tagged frame requests from the LLC.
- Presents them one at a time to the FrameTransmitter on the level-sensitive req line, then consumes the 2-bit ack (Fail=0, Success=1, NA=2).
- Reports a per-frame completion record back to the LLC, so the LLC can issue back-to-back requests without waiting on each transmission.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- TAG_W, 3, width of the frame tag carried with each request.
- MAX_RETRY, 2, re-queue attempts after Fail (used only with TXQ_RETRY_EN).
- GAP, 1, idle cycles forced between ack and the next req assertion, 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  LLC offers a request this cycle.
- enq_tag  in  TAG_W  tag of the offered request.
- enq_ready  out  1  queue can accept; high when count<DEPTH.
- req  out  1  to FrameTransmitter llc_f_ready; Req=1, NoReq=0.
- ack  in  2  from FrameTransmitter okay; Fail=0, Success=1, NA=2, 3 treated as NA.
- cur_tag  out  TAG_W  tag of the head entry; valid while req=1.
- done_valid  out  1  one-cycle pulse per completed frame.
- done_status  out  1  1=Success, 0=Fail (final); valid with done_valid.
- done_tag  out  TAG_W  tag of the completed frame.
- count  out  clog2(DEPTH)+1  entries held, including the in-flight head.
- overflow  out  1  sticky; set by enq_valid while enq_ready=0.

Behaviour:
- Reset (async on rst_n low):
  - Outputs: req=0, enq_ready=1, done_valid=0, done_status=0, done_tag=0, cur_tag=0, count=0, overflow=0.
  - Internal: pointers and retry counter cleared, state=IDLE.
  - Reset mid-transmission drops req immediately and discards all entries; no done pulse is issued.
- Storage: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH. The head stays stored until its completion.
- Enqueue: on a rising edge with enq_valid=1 and enq_ready=1, write enq_tag and increment count. enq_ready is registered from the post-update count.
- Simultaneous enqueue and dequeue in one cycle: count is unchanged, both pointers advance. A full queue does not accept in that cycle, because enq_ready was 0.
- FSM states IDLE, REQ, GAP_WAIT:
  - IDLE: if count>0, go to REQ and set req=1 on that edge. cur_tag = head tag.
  - REQ: req stays 1 while ack=NA. On ack=Success or Fail sampled at an edge:
    - on that same edge, req=0 and done_valid=1 with the status and head tag;
    - pop the head (rd_ptr+1, count-1);
    - load the gap counter with GAP and go to GAP_WAIT.
  - GAP_WAIT: decrement the gap counter each cycle; on reaching 0 go to IDLE.
  - Minimum req-low time is therefore GAP+1 cycles. This guarantees the FrameTransmitter sees req deasserted after its one-cycle oka pulse.
- Latency: an enqueue into an empty idle queue gives req=1 two edges after the enqueue edge (write, then IDLE->REQ).
- done_valid is exactly one cycle wide; it is never asserted without a preceding req=1 interval.
- An ack arriving while not in REQ (spurious) is ignored: no pop, no done.
- enq_valid while full: request dropped, overflow set, count unchanged. overflow clears only on reset.

Optional Feature:
- Macro: TXQ_RETRY_EN.
- Defined:
  - A Fail ack with retry_cnt<MAX_RETRY does not pop and does not pulse done_valid.
  - retry_cnt increments, req drops, GAP_WAIT runs, then the same head is re-requested.
  - A Fail with retry_cnt==MAX_RETRY gives final done_valid with done_status=0 and a pop.
  - retry_cnt clears on every pop.
- Undefined: every Fail is final; no retry counter logic exists.

Test Plan:
- Single request: enqueue tag 5 into empty queue -> req=1 two edges later, cur_tag=5; drive ack=Success after 6 cycles -> done_valid pulse with status 1, tag 5; req=0 for 2 cycles (GAP=1); count=0.
- Fill and overflow: enqueue tags 0..4 back-to-back with ack held NA -> enq_ready=0 after 4 accepted, overflow=1, count=4; then Success acks return done tags 0,1,2,3 in order.
- Concurrent enqueue and completion: queue full, enq_valid with tag 6 on the edge ack=Success is sampled -> tag 6 not accepted (enq_ready was 0); retry next cycle -> accepted, count=4, pointers wrap correctly.
- Fail without TXQ_RETRY_EN: ack=Fail -> done_valid with status 0, head popped, next tag requested after gap.
- Fail with TXQ_RETRY_EN, MAX_RETRY=2: three consecutive Fails -> req re-asserted twice with the same cur_tag, a single done_valid with status 0 after the third, count decremented once.
- Reset mid-operation: rst_n low while req=1 with 3 queued -> req=0, count=0, overflow=0 immediately, no done pulse; first enqueue after release behaves as in the single-request scenario.

Source files
------------

// File: rtl/llc_tx_queue_if.sv
// LLC <-> transmit-queue <-> FrameTransmitter signal bundle for llc_tx_queue.
// The master side is the LLC/FrameTransmitter environment; the slave side is the queue.
interface llc_tx_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic [TAG_W-1:0] enq_tag;
    logic             enq_ready;
    logic             req;
    logic [1:0]       ack;
    logic [TAG_W-1:0] cur_tag;
    logic             done_valid;
    logic             done_status;
    logic [TAG_W-1:0] done_tag;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output enq_valid, enq_tag, ack,
        input  enq_ready, req, cur_tag, done_valid, done_status, done_tag, count, overflow
    );

    modport slave (
        input  enq_valid, enq_tag, ack,
        output enq_ready, req, cur_tag, done_valid, done_status, done_tag, count, overflow
    );
endinterface

// File: rtl/llc_tx_queue.sv
// Transmit-request queue between the LLC and the FrameTransmitter, with per-frame completion records.
// Optional macro TXQ_RETRY_EN: re-request a failed head up to MAX_RETRY times before reporting Fail.
module llc_tx_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 3,
    parameter int MAX_RETRY = 2,
    parameter int GAP       = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    llc_tx_queue_if.slave  bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [2:0]       GAP_LD  = 3'(GAP);

    typedef enum logic [1:0] {
        ACK_FAIL    = 2'd0,
        ACK_SUCCESS = 2'd1,
        ACK_NA      = 2'd2
    } ack_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP_WAIT
    } state_e;

    state_e           state;
    logic [2:0]       gap_cnt;
    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             push;
    logic             acked;
    logic             final_ack;
    logic [CNT_W-1:0] count_next;

`ifdef TXQ_RETRY_EN
    localparam int             RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_cnt;
`else
    logic unused_max_retry;
    assign unused_max_retry = |MAX_RETRY;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push      = bus.enq_valid && bus.enq_ready;
        acked     = (state == REQ) &&
                    (bus.ack == ACK_SUCCESS || bus.ack == ACK_FAIL);
`ifdef TXQ_RETRY_EN
        final_ack = acked && (bus.ack == ACK_SUCCESS || retry_cnt >= RETRY_MAX);
`else
        final_ack = acked;
`endif
        count_next = bus.count;
        if (push && !final_ack) begin
            count_next = bus.count + 1'b1;
        end else if (final_ack && !push) begin
            count_next = bus.count - 1'b1;
        end
    end

    // NOTE: tag storage has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.enq_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.count     <= '0;
            bus.enq_ready <= 1'b1;
            bus.overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (final_ack) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            bus.count     <= count_next;
            bus.enq_ready <= (count_next < FULL);
            if (bus.enq_valid && !bus.enq_ready) begin
                bus.overflow <= 1'b1;
            end
        end
    end

`ifdef TXQ_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt <= '0;
        end else if (final_ack) begin
            retry_cnt <= '0;
        end else if (acked) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`endif

    // Request FSM; the head entry stays in storage until its completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            bus.req         <= 1'b0;
            bus.cur_tag     <= '0;
            bus.done_valid  <= 1'b0;
            bus.done_status <= 1'b0;
            bus.done_tag    <= '0;
        end else begin
            bus.done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.count != '0) begin
                        state       <= REQ;
                        bus.req     <= 1'b1;
                        bus.cur_tag <= mem[rd_ptr];
                    end
                end
                REQ: begin
                    if (acked) begin
                        bus.req <= 1'b0;
                        gap_cnt <= GAP_LD;
                        state   <= GAP_WAIT;
                        if (final_ack) begin
                            bus.done_valid  <= 1'b1;
                            bus.done_status <= (bus.ack == ACK_SUCCESS);
                            bus.done_tag    <= bus.cur_tag;
                        end
                    end
                end
                GAP_WAIT: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    // Leaving here after GAP cycles makes the req-low time GAP+1 cycles.
                    if (gap_cnt <= 3'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus.req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_llc_tx_queue.sv
// Self-checking bench for llc_tx_queue: directed scenarios plus random traffic against a queue-level model.
// Honours TXQ_RETRY_EN in its model when the macro is defined for the build.
module tb_llc_tx_queue;
    localparam int DEPTH     = 4;
    localparam int TAG_W     = 3;
    localparam int MAX_RETRY = 2;
    localparam int GAP       = 1;
    localparam logic [1:0] A_FAIL = 2'd0;
    localparam logic [1:0] A_OK   = 2'd1;
    localparam logic [1:0] A_NA   = 2'd2;
`ifdef TXQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llc_tx_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    llc_tx_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .MAX_RETRY(MAX_RETRY), .GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level model: a list of tags plus the cycle of the last req drop.
    int m_q[$];
    bit m_req, m_ovf, m_done, m_dstat;
    int m_cur, m_dtag, m_retry, e, last_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_req = 0; m_ovf = 0; m_done = 0; m_dstat = 0;
            m_cur = 0; m_dtag = 0; m_retry = 0; e = 0; last_drop = -100;
        end else begin
            bit push;
            e++;
            push   = bus.enq_valid && (m_q.size() < DEPTH);
            if (bus.enq_valid && m_q.size() >= DEPTH) m_ovf = 1;
            m_done = 0;
            if (m_req) begin
                if (bus.ack == A_OK || bus.ack == A_FAIL) begin
                    m_req = 0;
                    last_drop = e;
                    if (RETRY && bus.ack == A_FAIL && m_retry < MAX_RETRY) begin
                        m_retry++;
                    end else begin
                        m_done  = 1;
                        m_dstat = (bus.ack == A_OK);
                        m_dtag  = m_q.pop_front();
                        m_retry = 0;
                    end
                end
            end else if (m_q.size() > 0 && e >= last_drop + GAP + 1) begin
                m_req = 1;
                m_cur = m_q[0];
            end
            if (push) m_q.push_back(int'(bus.enq_tag));
        end
    end

    always @(negedge clk) begin
        check("req", bus.req, m_req);
        check("count", bus.count, m_q.size());
        check("enq_ready", bus.enq_ready, m_q.size() < DEPTH);
        check("overflow", bus.overflow, m_ovf);
        check("done_valid", bus.done_valid, m_done);
        if (m_done) begin
            check("done_status", bus.done_status, m_dstat);
            check("done_tag", bus.done_tag, m_dtag);
        end
        if (m_req) check("cur_tag", bus.cur_tag, m_cur);
    end

    task automatic cyc(input logic v, input int tag, input logic [1:0] a);
        bus.enq_valid = v;
        bus.enq_tag   = TAG_W'(tag);
        bus.ack       = a;
        @(posedge clk);
        #1;
    endtask

    task automatic single_request();
        cyc(1, 5, A_NA);
        check("sr_count_after_enq", bus.count, 1);
        check("sr_req_after_1_edge", bus.req, 0);
        cyc(0, 0, A_NA);
        check("sr_req_after_2_edges", bus.req, 1);
        check("sr_cur_tag", bus.cur_tag, 5);
        check("sr_model_req", m_req, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, A_NA);
        check("sr_req_held", bus.req, 1);
        cyc(0, 0, A_OK);
        check("sr_done_valid", bus.done_valid, 1);
        check("sr_done_status", bus.done_status, 1);
        check("sr_done_tag", bus.done_tag, 5);
        check("sr_model_dtag", m_dtag, 5);
        check("sr_req_drop", bus.req, 0);
        check("sr_count_zero", bus.count, 0);
        cyc(0, 0, A_NA);
        check("sr_done_one_cycle", bus.done_valid, 0);
        check("sr_req_low_1", bus.req, 0);
        cyc(0, 0, A_NA);
        check("sr_req_low_2", bus.req, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int got[$];
        int exp_tags[4];
        int rises, dones, last_stat;
        bit prev_req;

        bus.enq_valid = 0; bus.enq_tag = '0; bus.ack = A_NA;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", bus.req, 0);
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_count", bus.count, 0);
        check("rst_cur_tag", bus.cur_tag, 0);
        check("rst_done_tag", bus.done_tag, 0);
        rst_n = 1;

        single_request();

        // Fill past capacity with the transmitter holding NA.
        for (int i = 0; i < 5; i++) cyc(1, i, A_NA);
        check("fill_count", bus.count, 4);
        check("fill_enq_ready", bus.enq_ready, 0);
        check("fill_overflow", bus.overflow, 1);
        check("fill_cur_tag", bus.cur_tag, 0);
        check("fill_model_size", m_q.size(), 4);

        // Completion on the same edge as an offer to a full queue.
        cyc(1, 6, A_OK);
        check("conc_done_tag", bus.done_tag, 0);
        check("conc_count", bus.count, 3);
        check("conc_enq_ready", bus.enq_ready, 1);
        cyc(1, 6, A_NA);
        check("conc_retry_count", bus.count, 4);
        check("conc_retry_ready", bus.enq_ready, 0);

        exp_tags = '{1, 2, 3, 6};
        for (int i = 0; i < 60 && got.size() < 4; i++) begin
            cyc(0, 0, A_OK);
            if (bus.done_valid) got.push_back(int'(bus.done_tag));
        end
        check("drain_n_done", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("drain_order", got[i], exp_tags[i]);
        check("drain_count", bus.count, 0);

        // Transmitter failing every attempt.
        cyc(1, 2, A_NA);
        rises = 0; dones = 0; last_stat = -1; prev_req = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, A_FAIL);
            if (bus.req && !prev_req) rises++;
            prev_req = bus.req;
            if (bus.done_valid) begin
                dones++;
                last_stat = int'(bus.done_status);
            end
        end
        check("fail_req_rises", rises, RETRY ? 1 + MAX_RETRY : 1);
        check("fail_done_count", dones, 1);
        check("fail_done_status", last_stat, 0);
        check("fail_count", bus.count, 0);

        // Reset while a request is outstanding.
        for (int i = 1; i <= 3; i++) cyc(1, i, A_NA);
        cyc(0, 0, A_NA);
        check("pre_rst_req", bus.req, 1);
        rst_n = 0;
        #1;
        check("mid_rst_req", bus.req, 0);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_overflow", bus.overflow, 0);
        check("mid_rst_done", bus.done_valid, 0);
        cyc(0, 0, A_NA);
        rst_n = 1;
        cyc(0, 0, A_NA);
        single_request();

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [1:0] a;
            r = int'($urandom_range(0, 19));
            if (r < 11)      a = A_NA;
            else if (r < 12) a = 2'd3;
            else if (r < 17) a = A_OK;
            else             a = A_FAIL;
            cyc(($urandom_range(0, 9) < 4), int'($urandom_range(0, 7)), a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
